// File: rtl/core_pkg.sv
// core_pkg: shared types for the operand-forwarding controller.
//   fwd_sel_t    - select code for the ALU operand mux_3 (y0/y1/y2)
//   stage_info_t - destination/source info carried by one shadow stage
//   stage_hit    - "this stage produces register r" predicate
package core_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,  // regfile value (y0)
        FWD_WB  = 2'b01,  // WB result (y1)
        FWD_MEM = 2'b10   // MEM/ALU result, load data muxed in (y2)
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_info_t;

    // x0 is hardwired to zero, so it is never a forwarding source.
    function automatic logic stage_hit(stage_info_t s, logic [REG_ADDR_W-1:0] r);
        return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r);
    endfunction

endpackage

// File: rtl/forward_ctrl_fwd_compare.sv
// fwd_compare: picks the operand source for one ALU input.
//   src   - source register index of the instruction in EX
//   mem_i - MEM shadow stage
//   wb_i  - WB shadow stage
//   sel   - mux_3 select; MEM beats WB since it holds the younger producer
module fwd_compare
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  stage_info_t           mem_i,
    input  stage_info_t           wb_i,
    output fwd_sel_t              sel
);

    always_comb begin
        sel = FWD_REG;
        if (stage_hit(mem_i, src)) begin
            sel = FWD_MEM;
        end else if (stage_hit(wb_i, src)) begin
            sel = FWD_WB;
        end
    end

    // Source fields and the load flag are not needed past EX.
    logic unused_fields;
    assign unused_fields = ^{mem_i.rs1, mem_i.rs2, mem_i.mem_read,
                             wb_i.rs1, wb_i.rs2, wb_i.mem_read};

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: operand-forwarding and load-use hazard control.
// Tracks EX/MEM/WB destination info in a shadow pipeline and drives the two
// ALU operand mux selects plus a one-cycle load-use stall.
//   clk, reset            - core clock, synchronous active-high reset
//   id_*                  - instruction currently in ID
//   flush                 - taken branch/jump in EX; kills the ID instruction
//   stall                 - load-use hazard: hold PC and IF/ID, bubble EX
//   fwd_a_sel, fwd_b_sel  - operand A/B mux_3 selects (00 reg, 01 WB, 10 MEM)
//   ex_busy               - EX shadow stage holds a valid instruction
module forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  ex_busy
);

    import core_pkg::*;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    stage_info_t [NUM_STAGES-1:0] stg_q, stg_d;
    stage_info_t                  id_info;
    fwd_sel_t                     sel_a, sel_b;

    assign id_info = '{valid:     id_valid,
                       rs1:       id_rs1,
                       rs2:       id_rs2,
                       rd:        id_rd,
                       reg_write: id_reg_write,
                       mem_read:  id_mem_read};

    // A load in EX whose rd is read by ID cannot be forwarded in time; the
    // consumer waits one cycle. A flush kills the consumer, so no stall.
    always_comb begin
        stall = id_valid && stg_q[EX].valid && stg_q[EX].mem_read &&
                (stg_q[EX].rd != '0) &&
                ((stg_q[EX].rd == id_rs1) || (stg_q[EX].rd == id_rs2)) &&
                !flush;
    end

    // Older stages always advance; only the EX entry choice depends on
    // flush/stall (both insert a bubble).
    always_comb begin
        stg_d = stg_q;
        for (int s = NUM_STAGES - 1; s > 0; s--) begin
            stg_d[s] = stg_q[s-1];
        end
        stg_d[EX] = (flush || stall) ? '0 : id_info;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    fwd_compare u_cmp_a (
        .src   (stg_q[EX].rs1),
        .mem_i (stg_q[MEM]),
        .wb_i  (stg_q[WB]),
        .sel   (sel_a)
    );

    fwd_compare u_cmp_b (
        .src   (stg_q[EX].rs2),
        .mem_i (stg_q[MEM]),
        .wb_i  (stg_q[WB]),
        .sel   (sel_b)
    );

    assign fwd_a_sel = sel_a;
    assign fwd_b_sel = sel_b;
    assign ex_busy   = stg_q[EX].valid;

endmodule
